conv3x3_engine: RTL and testbench
=================================

Name: conv3x3_engine

Overview:
Streaming 3x3 "valid" 2-D convolution (no padding) over one single-channel signed image frame of IMG_HEIGHT x IMG_WIDTH pixels. Pixels arrive in raster order over a valid/ready input stream. The block emits (IMG_HEIGHT-2)*(IMG_WIDTH-2) signed results in raster order over a valid/ready output stream, then pulses done. It sits in the CNN feature-extraction datapath between the pixel source and downstream activation/pooling.

Parameters:
DATA_WIDTH, 8, bit width of pixels and weights (signed two's complement)
ACC_WIDTH, 16, bit width of accumulated result (signed)
IMG_HEIGHT, 6, frame rows (>=3)
IMG_WIDTH, 6, frame columns (>=3)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse in IDLE; begins a frame
in_data  input  DATA_WIDTH  signed pixel, raster order
in_valid  input  1  in_data valid
in_ready  output  1  engine accepts pixel this cycle
weight_flat  input  9*DATA_WIDTH  kernel; w[k] = bits [k*DATA_WIDTH +: DATA_WIDTH], k = dr*3+dc, row-major
out_data  output  ACC_WIDTH  signed convolution result
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; in_ready=0, out_valid=0, out_data=0, done=0; pixel row/col counters, output counter and window cleared. Reset mid-frame aborts the frame; no partial done is issued.
- States: IDLE -> (start) RUN -> (last output transferred) DONE -> IDLE. DONE lasts exactly one cycle with done=1. start is ignored outside IDLE.
- Weights: weight_flat is latched into internal registers on the start cycle and used for the whole frame.
- in_ready = (state==RUN) and (pixels accepted < IMG_HEIGHT*IMG_WIDTH) and (!out_valid or out_ready).
- Pixel transfer occurs when in_valid && in_ready. Each accepted pixel is written into two IMG_WIDTH-deep line buffers (rows r-1, r-2) and a 3x3 window shift register. The row/col counters advance in raster order.
- When the accepted pixel is at (r,c) with r>=2 and c>=2, the window for output (r-2,c-2) is complete. out_data = sum over dr,dc of w[dr*3+dc] * pixel[r-2+dr][c-2+dc].
- Arithmetic: signed DATA_WIDTH x DATA_WIDTH products, sign-extended and summed. The result is truncated to ACC_WIDTH (two's-complement wrap, no saturation).
- Latency: out_valid and out_data are registered and asserted the cycle after the completing pixel is accepted.
- out_data holds stable while out_valid && !out_ready. Input is stalled through in_ready, so no result is ever dropped.
- The output transfer is out_valid && out_ready. out_valid clears after the transfer unless a new result is produced in the same cycle.
- After the (IMG_HEIGHT-2)*(IMG_WIDTH-2)-th output transfer, the engine enters DONE. done is high for one cycle; it returns to IDLE with in_ready=0.
- Pixels in rows 0-1 and columns 0-1 produce no output. Pixels presented while in_ready=0 are not consumed.
- Line buffers wrap at column IMG_WIDTH-1. The window is refilled at the start of each row: the first two columns of a row never yield output.

Decomposition:
- Shared package: state enumeration (IDLE, RUN, DONE) and a constant for the kernel tap count (9).
- One natural sub-module: conv3x3_line_buffer. It holds the two-row line buffer plus the 3x3 window shift register and exposes 9 window taps.
- The MAC tree, counters, FSM and output register stay in conv3x3_engine.

Test Plan:
- Image pixel[r][c]=r*6+c+1 (6x6), identity kernel (0,0,0,0,1,0,0,0,0), out_ready=1 -> 16 outputs equal pixel[r+1][c+1]; out[0]=8, out[15]=29; done pulses once.
- Same image, all-ones kernel -> 3x3 neighbourhood sums; out[0]=72, out[15]=261.
- Same image, edge kernel (-1 x8, centre 8) -> all 16 outputs 0 (signed weights handled).
- Backpressure: toggle out_ready randomly -> identical 16 all-ones results; in_ready=0 whenever out_valid && !out_ready; no loss or duplication.
- Gapped input: in_valid randomly deasserted -> identical results; outputs only after row 2, col 2 pixels.
- Reset mid-frame after 20 pixels, then a full frame with start -> no done from the aborted frame; the new frame's 16 outputs are correct; all outputs 0 during reset.

Source files
------------

// File: rtl/conv3x3_engine_pkg.sv
// rtl/conv3x3_engine_pkg.sv - shared state encoding and kernel constants for the 3x3 convolution engine
package conv3x3_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int KERNEL_TAPS = 9;

endpackage

// File: rtl/conv3x3_line_buffer.sv
// rtl/conv3x3_line_buffer.sv - two-row line buffer plus 3x3 window exposing nine taps
// Taps show the window as it is once the pixel on pix_i lands, so the MAC can use them in the same cycle.
module conv3x3_line_buffer
    import conv3x3_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 6,
    localparam int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear_i,
    input  logic                              shift_i,
    input  logic [COL_W-1:0]                  col_i,
    input  logic [DATA_WIDTH-1:0]             pix_i,
    output logic [KERNEL_TAPS*DATA_WIDTH-1:0] taps_o
);

    logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win_q [3][2];
    logic [DATA_WIDTH-1:0] new_col [3];

    // Newest window column: row r-2, row r-1, current pixel.
    always_comb begin
        new_col[0] = lb2_q[col_i];
        new_col[1] = lb1_q[col_i];
        new_col[2] = pix_i;
    end

    always_comb begin
        taps_o = '0;
        for (int dr = 0; dr < 3; dr++) begin
            taps_o[(dr*3+0)*DATA_WIDTH +: DATA_WIDTH] = win_q[dr][0];
            taps_o[(dr*3+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[dr][1];
            taps_o[(dr*3+2)*DATA_WIDTH +: DATA_WIDTH] = new_col[dr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            for (int dr = 0; dr < 3; dr++) begin
                win_q[dr][0] <= '0;
                win_q[dr][1] <= '0;
            end
        end else if (shift_i) begin
            lb1_q[col_i] <= pix_i;
            lb2_q[col_i] <= lb1_q[col_i];
            for (int dr = 0; dr < 3; dr++) begin
                win_q[dr][0] <= win_q[dr][1];
                win_q[dr][1] <= new_col[dr];
            end
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - streaming 3x3 valid convolution over one raster-order frame
module conv3x3_engine
    import conv3x3_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int IMG_HEIGHT = 6,
    parameter int IMG_WIDTH  = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic signed [DATA_WIDTH-1:0]       in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [KERNEL_TAPS*DATA_WIDTH-1:0]  weight_flat,
    output logic signed [ACC_WIDTH-1:0]        out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               done
);

    localparam int NUM_PIX = IMG_HEIGHT * IMG_WIDTH;
    localparam int NUM_OUT = (IMG_HEIGHT - 2) * (IMG_WIDTH - 2);
    localparam int COL_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W   = $clog2(IMG_HEIGHT);
    localparam int PIX_W   = $clog2(NUM_PIX + 1);
    localparam int OUT_W   = $clog2(NUM_OUT + 1);
    localparam int SUM_W   = (ACC_WIDTH > 2*DATA_WIDTH + 4) ? ACC_WIDTH : 2*DATA_WIDTH + 4;

    state_e                            state_q, state_d;
    logic [KERNEL_TAPS*DATA_WIDTH-1:0] weights_q;
    logic [KERNEL_TAPS*DATA_WIDTH-1:0] taps;
    logic [ROW_W-1:0]                  row_q;
    logic [COL_W-1:0]                  col_q;
    logic [PIX_W-1:0]                  pix_cnt_q;
    logic [OUT_W-1:0]                  out_cnt_q;
    logic                              out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0]       out_data_q, out_data_d;
    logic signed [SUM_W-1:0]           mac_sum;
    logic                              start_frame, pix_fire, out_fire, win_ready, last_out;

    assign start_frame = (state_q == ST_IDLE) && start;
    assign pix_fire    = in_valid && in_ready;
    assign out_fire    = out_valid_q && out_ready;
    assign win_ready   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_out    = out_fire && (out_cnt_q == OUT_W'(NUM_OUT - 1));

    conv3x3_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_frame),
        .shift_i (pix_fire),
        .col_i   (col_q),
        .pix_i   (in_data),
        .taps_o  (taps)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_out) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_RUN) && (pix_cnt_q < PIX_W'(NUM_PIX)) && (!out_valid_q || out_ready);
        done     = (state_q == ST_DONE);
    end

    // Products are widened before summing; the final slice gives two's-complement wrap.
    always_comb begin
        mac_sum = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            mac_sum = mac_sum + SUM_W'($signed(weights_q[k*DATA_WIDTH +: DATA_WIDTH])
                                     * $signed(taps[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (pix_fire && win_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = mac_sum[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weights_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pix_cnt_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (start_frame) begin
            weights_q   <= weight_flat;
            row_q       <= '0;
            col_q       <= '0;
            pix_cnt_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= out_data_q;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (pix_fire) begin
                pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            if (out_fire) begin
                out_cnt_q <= out_cnt_q + OUT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - directed-vector bench for conv3x3_engine on a 6x6 frame
module tb_conv3x3_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [7:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [71:0]        weight_flat;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               done;

    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 kern [9];
    logic signed [15:0] got [16];

    always #5 clk = ~clk;

    conv3x3_engine #(
        .DATA_WIDTH (8),
        .ACC_WIDTH  (16),
        .IMG_HEIGHT (6),
        .IMG_WIDTH  (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .weight_flat (weight_flat),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // pixel[r][c] = r*6+c+1, output o sits at (o/4, o%4)
    function automatic logic signed [15:0] exp_out(input int o);
        int r, c, s;
        r = o / 4;
        c = o % 4;
        s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += kern[dr*3+dc] * ((r+dr)*6 + (c+dc) + 1);
        return s[15:0];
    endfunction

    task automatic run_frame(input string name, input bit bp, input bit gap, input int abort_at);
        int pix_idx  = 0;
        int out_idx  = 0;
        int done_cnt = 0;
        bit seen_first = 0;
        bit finished   = 0;
        @(negedge clk);
        for (int k = 0; k < 9; k++) weight_flat[k*8 +: 8] = kern[k][7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        weight_flat = '0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (pix_idx < 36) && (!gap || $urandom_range(0, 1) == 1);
            in_data   = 8'(pix_idx + 1);
            #1;
            if (done) begin
                done_cnt++;
                finished = 1;
            end
            if (out_valid && !seen_first) begin
                seen_first = 1;
                check({name, " first_out_pixels"}, pix_idx, 15);
            end
            if (out_valid && !out_ready) check({name, " stall_in_ready"}, in_ready, 0);
            if (out_valid && out_ready) begin
                if (out_idx < 16) begin
                    got[out_idx] = out_data;
                    check($sformatf("%s out%0d", name, out_idx), out_data, exp_out(out_idx));
                end else begin
                    check({name, " extra_output"}, out_idx, 15);
                end
                out_idx++;
            end
            if (in_valid && in_ready) pix_idx++;
            if (abort_at > 0 && pix_idx >= abort_at) finished = 1;
            if (!finished) @(negedge clk);
        end
        check({name, " terminated"}, finished, 1);
        if (abort_at == 0) begin
            check({name, " out_count"}, out_idx, 16);
            check({name, " done_count"}, done_cnt, 1);
            @(negedge clk);
            #1;
            check({name, " done_after"}, done, 0);
            check({name, " in_ready_idle"}, in_ready, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        weight_flat = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset done", done, 0);
        rst = 1'b0;

        kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        run_frame("identity", 0, 0, 0);
        check("identity first", got[0], 8);
        check("identity last", got[15], 29);

        kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_frame("ones", 0, 0, 0);
        check("ones first", got[0], 72);
        check("ones last", got[15], 261);

        kern = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
        run_frame("edge", 0, 0, 0);
        check("edge first", got[0], 0);

        kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_frame("backpressure", 1, 0, 0);
        check("backpressure last", got[15], 261);
        run_frame("gapped", 0, 1, 0);
        check("gapped first", got[0], 72);
        run_frame("both", 1, 1, 0);

        kern = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        run_frame("wrap", 0, 0, 0);
        check("wrap first", got[0], -9216);
        check("wrap last", got[15], 32128);

        kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_frame("abort", 0, 0, 20);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("abort rst out_valid", out_valid, 0);
            check("abort rst out_data", out_data, 0);
            check("abort rst done", done, 0);
            check("abort rst in_ready", in_ready, 0);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("abort no_done", done, 0);
        end
        run_frame("after_abort", 0, 0, 0);
        check("after_abort first", got[0], 72);
        check("after_abort last", got[15], 261);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
